// File: rtl/note_defs_pkg.sv
// Shared note codes and sequencer state encodings for the chart sequencer.
// A chart entry packs the up lane in [3:2] and the down lane in [1:0].
package note_defs_pkg;

  typedef enum logic [1:0] {
    NOTE_NOTHING     = 2'b00,
    NOTE_TAP         = 2'b01,
    NOTE_HOLD_START  = 2'b10,
    NOTE_HOLD_MIDDLE = 2'b11
  } note_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_e;

  localparam int ENTRY_W = 4;
  localparam logic [ENTRY_W-1:0] ENTRY_EMPTY = {NOTE_NOTHING, NOTE_NOTHING};

endpackage

// File: rtl/note_prefetch.sv
// One-entry prefetch buffer in front of a synchronous ROM: registers the read
// strobe, captures the returned word one cycle later and flags it valid.
module note_prefetch
  import note_defs_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_req_addr,
  input  logic               i_consume,
  input  logic [ENTRY_W-1:0] i_rom_data,
  output logic               o_rom_en,
  output logic [ADDR_W-1:0]  o_rom_addr,
  output logic [ENTRY_W-1:0] o_data,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_capture
);

  logic               r_rom_en;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_pending;
  logic               r_valid;
  logic [ENTRY_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
      r_pending  <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= ENTRY_EMPTY;
    end else begin
      r_rom_en  <= i_req;
      if (i_req) begin
        r_rom_addr <= i_req_addr;
      end
      r_pending <= r_rom_en;
      // Returning data beats a same-cycle consume so no chart entry is lost.
      if (r_pending) begin
        r_data  <= i_rom_data;
        r_valid <= 1'b1;
      end else if (i_consume) begin
        r_data  <= ENTRY_EMPTY;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_rom_en   = r_rom_en;
  assign o_rom_addr = r_rom_addr;
  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_busy     = r_rom_en | r_pending;
  assign o_capture  = r_pending;

endmodule

// File: rtl/chart_sequencer.sv
// Feeds the judgement block a two-slot note window (current/next beat) from the
// chart ROM, advancing on each beat tick with start, pause and end-of-song drain.
module chart_sequencer
  import note_defs_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DRAIN_BEATS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_tick,
  input  logic              start,
  input  logic              pause,
  input  logic [ADDR_W:0]   song_len,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [3:0]        rom_data,
  output logic [1:0]        left_noteup,
  output logic [1:0]        left_notedown,
  output logic [1:0]        right_noteup,
  output logic [1:0]        right_notedown,
  output logic              playing,
  output logic              song_done,
  output logic              underrun,
  output logic [ADDR_W:0]   beat_count
);

  localparam int DCW = (DRAIN_BEATS > 1) ? $clog2(DRAIN_BEATS) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_BEATS - 1);

  seq_state_e         r_state;
  seq_state_e         r_ret_state;
  logic [ADDR_W:0]    r_len;
  logic [ADDR_W:0]    r_ptr;
  logic [ENTRY_W-1:0] r_left;
  logic [ENTRY_W-1:0] r_right;
  logic               r_playing;
  logic               r_done;
  logic               r_underrun;
  logic [ADDR_W:0]    r_beat_count;
  logic [DCW-1:0]     r_drain_cnt;

  logic               w_start_ok;
  logic               w_play_tick;
  logic               w_req;
  logic [ADDR_W-1:0]  w_req_addr;
  logic [ENTRY_W-1:0] w_buf_data;
  logic               w_buf_valid;
  logic               w_busy;
  logic               w_capture;

  assign w_start_ok  = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_play_tick = (r_state == ST_PLAY) && beat_tick && !pause;
  // A fetch already in flight stands in for the one this tick would issue.
  assign w_req       = (w_start_ok && song_len != '0) ||
                       (w_play_tick && !w_busy && r_ptr < r_len);
  assign w_req_addr  = w_start_ok ? '0 : r_ptr[ADDR_W-1:0];

  note_prefetch #(
    .ADDR_W (ADDR_W)
  ) u_prefetch (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_req),
    .i_req_addr (w_req_addr),
    .i_consume  (w_play_tick),
    .i_rom_data (rom_data),
    .o_rom_en   (rom_en),
    .o_rom_addr (rom_addr),
    .o_data     (w_buf_data),
    .o_valid    (w_buf_valid),
    .o_busy     (w_busy),
    .o_capture  (w_capture)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ret_state  <= ST_PLAY;
      r_len        <= '0;
      r_ptr        <= '0;
      r_left       <= ENTRY_EMPTY;
      r_right      <= ENTRY_EMPTY;
      r_playing    <= 1'b0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
      r_beat_count <= '0;
      r_drain_cnt  <= '0;
    end else begin
      if (w_capture) begin
        r_ptr <= r_ptr + 1'b1;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_len        <= song_len;
            r_ptr        <= '0;
            r_underrun   <= 1'b0;
            r_beat_count <= '0;
            r_left       <= ENTRY_EMPTY;
            r_right      <= ENTRY_EMPTY;
            r_playing    <= 1'b0;
            if (song_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_PRIME;
              r_done  <= 1'b0;
            end
          end
        end
        ST_PRIME: begin
          if (w_capture) begin
            r_state   <= ST_PLAY;
            r_playing <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (pause) begin
            r_state     <= ST_PAUSED;
            r_ret_state <= ST_PLAY;
          end else if (beat_tick) begin
            r_left  <= r_right;
            r_right <= w_buf_valid ? w_buf_data : ENTRY_EMPTY;
            if (!w_buf_valid) begin
              r_underrun <= 1'b1;
            end
            if (r_beat_count != '1) begin
              r_beat_count <= r_beat_count + 1'b1;
            end
            // Every entry has been fetched and handed over: only blanks remain.
            if (!w_busy && r_ptr == r_len) begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (pause) begin
            r_state     <= ST_PAUSED;
            r_ret_state <= ST_DRAIN;
          end else if (beat_tick) begin
            r_left  <= r_right;
            r_right <= ENTRY_EMPTY;
            if (r_drain_cnt == DRAIN_LAST) begin
              r_state   <= ST_DONE;
              r_playing <= 1'b0;
              r_done    <= 1'b1;
              r_left    <= ENTRY_EMPTY;
            end else begin
              r_drain_cnt <= r_drain_cnt + 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            r_state <= r_ret_state;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign left_noteup    = r_left[3:2];
  assign left_notedown  = r_left[1:0];
  assign right_noteup   = r_right[3:2];
  assign right_notedown = r_right[1:0];
  assign playing        = r_playing;
  assign song_done      = r_done;
  assign underrun       = r_underrun;
  assign beat_count     = r_beat_count;

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer: a window/beat_count scoreboard fed at each
// driven tick, plus a log of ROM addresses checked against the expected order.
module tb_chart_sequencer;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, beat_tick, start, pause;
  logic [AW:0]   song_len;
  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic [3:0]    rom_data;
  logic [1:0]    lu, ld, ru, rd;
  logic          playing, song_done, underrun;
  logic [AW:0]   beat_count;

  logic [3:0]    rom [0:(1<<AW)-1];
  logic [AW-1:0] addr_log[$];

  typedef struct packed {
    logic [7:0]  win;
    logic [AW:0] bc;
  } exp_t;
  exp_t sb[$];

  int          total = 0;
  int          bad   = 0;
  bit          verbose = 1'b1;
  logic [3:0]  exp_l, exp_r;
  logic [AW:0] exp_bc;
  int          nxt, len_m;

  chart_sequencer #(.ADDR_W(AW), .DRAIN_BEATS(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .beat_tick      (beat_tick),
    .start          (start),
    .pause          (pause),
    .song_len       (song_len),
    .rom_addr       (rom_addr),
    .rom_en         (rom_en),
    .rom_data       (rom_data),
    .left_noteup    (lu),
    .left_notedown  (ld),
    .right_noteup   (ru),
    .right_notedown (rd),
    .playing        (playing),
    .song_done      (song_done),
    .underrun       (underrun),
    .beat_count     (beat_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];
  always @(negedge clk) if (rom_en) addr_log.push_back(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] win_now();
    return {lu, ld, ru, rd};
  endfunction

  task automatic push_exp();
    exp_t e;
    e.win = {exp_l, exp_r};
    e.bc  = exp_bc;
    sb.push_back(e);
  endtask

  // Window model: each accepted tick shifts the next chart entry (or a blank
  // once the chart is exhausted) in on the right; only chart entries count.
  task automatic model_tick();
    exp_l = exp_r;
    if (nxt < len_m) begin
      exp_r = rom[nxt];
      exp_bc++;
    end else begin
      exp_r = 4'b0000;
    end
    nxt++;
    push_exp();
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_win"}, {24'd0, win_now()}, {24'd0, e.win});
      check({tag, "_bc"}, {21'd0, beat_count}, {21'd0, e.bc});
      if (verbose) $display("tick %s win=%b bc=%0d exp_win=%b exp_bc=%0d",
                            tag, win_now(), beat_count, e.win, e.bc);
    end
  endtask

  // Entered at a negedge; the tick is sampled on the next posedge.
  task automatic tick(input string tag);
    beat_tick = 1'b1;
    @(negedge clk);
    beat_tick = 1'b0;
    pop_check(tag);
  endtask

  task automatic start_song(input int len);
    addr_log.delete();
    song_len = (AW+1)'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nxt = 0; len_m = len;
    exp_l = 4'b0000; exp_r = 4'b0000; exp_bc = '0;
  endtask

  task automatic check_addrs(input string tag, input int n);
    bit ok;
    ok = (addr_log.size() == n);
    for (int i = 0; i < addr_log.size() && ok; i++)
      if (addr_log[i] !== AW'(i)) ok = 1'b0;
    check(tag, {31'd0, ok}, 32'd1);
    $display("addr %s logged=%0d expected=%0d", tag, addr_log.size(), n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; beat_tick = 1'b0; start = 1'b0; pause = 1'b0; song_len = '0;
    cyc(3);
    check("rst_win", {24'd0, win_now()}, 32'd0);
    check("rst_rom_en", {31'd0, rom_en}, 32'd0);
    check("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_done", {31'd0, song_done}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_bc", {21'd0, beat_count}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // Three-entry song from the reference chart, ticks every 20 clocks
    rom[0] = 4'b0100; rom[1] = 4'b0001; rom[2] = 4'b1011;
    start_song(3);
    check("s1_first_rom_en", {31'd0, rom_en}, 32'd1);
    check("s1_first_rom_addr", {22'd0, rom_addr}, 32'd0);
    check("s1_prime_playing", {31'd0, playing}, 32'd0);
    cyc(5);
    check("s1_playing", {31'd0, playing}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      model_tick();
      tick("s1");
      if (i == 2) check("s1_tick3_const", {24'd0, win_now()}, 32'h1B);
      cyc(19);
    end
    check("s1_done", {31'd0, song_done}, 32'd1);
    check("s1_not_playing", {31'd0, playing}, 32'd0);
    check("s1_bc3", {21'd0, beat_count}, 32'd3);
    check_addrs("s1_addrs", 3);

    // Empty song goes straight to done without touching the ROM
    start_song(0);
    check("s2_done", {31'd0, song_done}, 32'd1);
    check("s2_rom_en", {31'd0, rom_en}, 32'd0);
    cyc(5);
    check_addrs("s2_no_fetch", 0);

    // Pause across two ticks mid-song
    for (int i = 0; i < 8; i++) rom[i] = 4'($urandom);
    start_song(8);
    check("s3_done_cleared", {31'd0, song_done}, 32'd0);
    cyc(5);
    for (int i = 0; i < 3; i++) begin
      model_tick(); tick("s3_pre"); cyc(19);
    end
    pause = 1'b1;
    cyc(2);
    for (int i = 0; i < 2; i++) begin
      push_exp(); tick("s3_paused"); cyc(5);
    end
    check("s3_paused_playing", {31'd0, playing}, 32'd1);
    pause = 1'b0;
    cyc(2);
    for (int i = 0; i < 7; i++) begin
      model_tick(); tick("s3_post"); cyc(19);
    end
    check("s3_done", {31'd0, song_done}, 32'd1);
    check("s3_bc8", {21'd0, beat_count}, 32'd8);
    check_addrs("s3_addrs", 8);

    // Back-to-back ticks starve the buffer, then reset with a fetch in flight
    for (int i = 0; i < 6; i++) rom[i] = 4'($urandom);
    start_song(6);
    cyc(5);
    model_tick(); tick("s4_t1"); cyc(19);
    model_tick();
    beat_tick = 1'b1;
    @(negedge clk);
    pop_check("s4_t2");
    exp_l = exp_r; exp_r = 4'b0000; exp_bc++;
    push_exp();
    @(negedge clk);
    beat_tick = 1'b0;
    pop_check("s4_underrun_tick");
    check("s4_underrun", {31'd0, underrun}, 32'd1);
    cyc(19);
    model_tick(); tick("s4_t4_inflight_entry"); cyc(19);
    check("s4_underrun_sticky", {31'd0, underrun}, 32'd1);
    model_tick();
    beat_tick = 1'b1;
    @(negedge clk);
    beat_tick = 1'b0;
    pop_check("s4_t5");
    check("s4_fetch_in_flight", {31'd0, rom_en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s4_rst_win", {24'd0, win_now()}, 32'd0);
    check("s4_rst_underrun", {31'd0, underrun}, 32'd0);
    check("s4_rst_playing", {31'd0, playing}, 32'd0);
    check("s4_rst_bc", {21'd0, beat_count}, 32'd0);
    cyc(4);
    check("s4_late_data_win", {24'd0, win_now()}, 32'd0);
    check("s4_late_rom_en", {31'd0, rom_en}, 32'd0);
    check("s4_late_done", {31'd0, song_done}, 32'd0);

    // Full-length song: addresses 0..1023 with no wrap
    for (int i = 0; i < (1 << AW); i++) rom[i] = 4'($urandom);
    verbose = 1'b0;
    start_song(1 << AW);
    cyc(5);
    for (int i = 0; i < (1 << AW); i++) begin
      model_tick(); tick("s5"); cyc(3);
    end
    verbose = 1'b1;
    check("s5_bc1024", {21'd0, beat_count}, 32'd1024);
    check("s5_still_playing", {31'd0, playing}, 32'd1);
    check_addrs("s5_addrs", 1 << AW);
    for (int i = 0; i < 2; i++) begin
      model_tick(); tick("s5_drain"); cyc(3);
    end
    check("s5_done", {31'd0, song_done}, 32'd1);
    check("s5_final_win", {24'd0, win_now()}, 32'd0);
    check_addrs("s5_no_extra_fetch", 1 << AW);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
